// File: rtl/ibis_video_timing_gen_if.sv
// -----------------------------------------------------------------------------
// ibis_video_timing_gen_if
//
// Bundle of control and timing signals between the Ibis raster timing
// generator and the pixel fetch / encoder stages.
//
// Signals:
//   enable       advance timing when high, freeze when low
//   restart      synchronous return to raster position (0,0)
//   pix_stb      one-cycle strobe: the fields below describe a new pixel
//   hsync/vsync  sync outputs at the configured polarity
//   hblank       pixel column is outside the active width
//   vblank       line is outside the active height
//   de           pixel is inside the active picture
//   line_start   strobe qualifier: presented pixel is column 0
//   frame_start  strobe qualifier: presented pixel is (0,0)
//   ord_x/ord_y  raster coordinates of the presented pixel
//   frame_cnt    completed-frame count (wrapping)
//
// Modports:
//   master  the timing generator (drives timing, receives enable/restart)
//   slave   the consumer (drives enable/restart, receives timing)
// -----------------------------------------------------------------------------
interface ibis_video_timing_gen_if #(
    parameter int WIDTH       = 12,
    parameter int FRAME_CNT_W = 16
);
    logic                   enable;
    logic                   restart;
    logic                   pix_stb;
    logic                   hsync;
    logic                   vsync;
    logic                   hblank;
    logic                   vblank;
    logic                   de;
    logic                   line_start;
    logic                   frame_start;
    logic [WIDTH-1:0]       ord_x;
    logic [WIDTH-1:0]       ord_y;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        input  enable,
        input  restart,
        output pix_stb,
        output hsync,
        output vsync,
        output hblank,
        output vblank,
        output de,
        output line_start,
        output frame_start,
        output ord_x,
        output ord_y,
        output frame_cnt
    );

    modport slave (
        output enable,
        output restart,
        input  pix_stb,
        input  hsync,
        input  vsync,
        input  hblank,
        input  vblank,
        input  de,
        input  line_start,
        input  frame_start,
        input  ord_x,
        input  ord_y,
        input  frame_cnt
    );
endinterface

// File: rtl/ibis_video_timing_gen.sv
// -----------------------------------------------------------------------------
// ibis_video_timing_gen
//
// Parametrised raster timing generator. A clock divider turns aclk into a
// pixel tick; on every tick the current raster position (x,y) is decoded into
// sync / blank / data-enable levels, presented on the outputs together with a
// one-cycle pix_stb, and the position advances in raster order.
//
// Ports:
//   aclk      clock (TMDS rate)
//   aresetn   asynchronous active-low reset
//   vt        ibis_video_timing_gen_if.master
//               in : enable, restart
//               out: pix_stb, hsync, vsync, hblank, vblank, de, line_start,
//                    frame_start, ord_x, ord_y, frame_cnt
//
// Output timing: all outputs are registered and stay constant from the
// pix_stb cycle until the next tick. restart and aresetn return everything to
// the idle (reset) state; restart leaves frame_cnt untouched.
// -----------------------------------------------------------------------------
module ibis_video_timing_gen #(
    parameter int WIDTH       = 12,
    parameter int CLK_DIV     = 5,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int H_SYNC_POL  = 0,
    parameter int V_SYNC_POL  = 0,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    ibis_video_timing_gen_if.master  vt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Parameter sanity: counters must be able to hold the last position and
    // the sync windows must be non-empty for the inclusive-range decode.
    if (CLK_DIV < 1) begin : g_bad_div
        $error("ibis_video_timing_gen: CLK_DIV must be >= 1");
    end
    if ((longint'(H_TOTAL) - 1) >= (longint'(1) << WIDTH)) begin : g_bad_hw
        $error("ibis_video_timing_gen: WIDTH too small for H_TOTAL-1");
    end
    if ((longint'(V_TOTAL) - 1) >= (longint'(1) << WIDTH)) begin : g_bad_vw
        $error("ibis_video_timing_gen: WIDTH too small for V_TOTAL-1");
    end
    if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_geom
        $error("ibis_video_timing_gen: sync widths and active sizes must be >= 1");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0] H_LAST   = WIDTH'(H_TOTAL - 1);
    localparam logic [WIDTH-1:0] V_LAST   = WIDTH'(V_TOTAL - 1);
    localparam logic [WIDTH-1:0] H_ACT    = WIDTH'(H_ACTIVE);
    localparam logic [WIDTH-1:0] V_ACT    = WIDTH'(V_ACTIVE);
    // Sync windows as inclusive ranges so the end never exceeds H/V_TOTAL-1.
    localparam logic [WIDTH-1:0] HS_FIRST = WIDTH'(H_ACTIVE + H_FP);
    localparam logic [WIDTH-1:0] HS_LAST  = WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [WIDTH-1:0] VS_FIRST = WIDTH'(V_ACTIVE + V_FP);
    localparam logic [WIDTH-1:0] VS_LAST  = WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             HS_ON    = (H_SYNC_POL != 0);
    localparam logic             VS_ON    = (V_SYNC_POL != 0);

    // Decode helpers
    function automatic logic f_hsync(input logic [WIDTH-1:0] x);
        return ((x >= HS_FIRST) && (x <= HS_LAST)) ? HS_ON : ~HS_ON;
    endfunction

    function automatic logic f_vsync(input logic [WIDTH-1:0] y);
        return ((y >= VS_FIRST) && (y <= VS_LAST)) ? VS_ON : ~VS_ON;
    endfunction

    // Control state
    logic [DIV_W-1:0]       r_div;
    logic [WIDTH-1:0]       r_x;
    logic [WIDTH-1:0]       r_y;
    logic                   r_first;     // next frame_start is the first since reset/restart

    // Registered outputs
    logic                   r_pix_stb;
    logic                   r_line_start;
    logic                   r_frame_start;
    logic                   r_hsync;
    logic                   r_vsync;
    logic                   r_hblank;
    logic                   r_vblank;
    logic                   r_de;
    logic [WIDTH-1:0]       r_ord_x;
    logic [WIDTH-1:0]       r_ord_y;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    logic tick;
    logic at_x0;
    logic at_origin;

    assign tick      = vt.enable && (r_div == DIV_LAST);
    assign at_x0     = (r_x == '0);
    assign at_origin = at_x0 && (r_y == '0);

    // ---- divider / position / output registers ----
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_div         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_first       <= 1'b1;
            r_pix_stb     <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_hsync       <= ~HS_ON;
            r_vsync       <= ~VS_ON;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_de          <= 1'b0;
            r_ord_x       <= '0;
            r_ord_y       <= '0;
            r_frame_cnt   <= '0;
        end else if (vt.restart) begin
            // Same idle state as reset, but the frame count is kept.
            r_div         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_first       <= 1'b1;
            r_pix_stb     <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_hsync       <= ~HS_ON;
            r_vsync       <= ~VS_ON;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_de          <= 1'b0;
            r_ord_x       <= '0;
            r_ord_y       <= '0;
        end else begin
            r_pix_stb     <= tick;
            r_line_start  <= tick && at_x0;
            r_frame_start <= tick && at_origin;

            // A partial divide count is simply held while enable is low.
            if (vt.enable) begin
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
            end

            if (tick) begin
                r_hsync  <= f_hsync(r_x);
                r_vsync  <= f_vsync(r_y);
                r_hblank <= (r_x >= H_ACT);
                r_vblank <= (r_y >= V_ACT);
                r_de     <= (r_x < H_ACT) && (r_y < V_ACT);
                r_ord_x  <= r_x;
                r_ord_y  <= r_y;

                // The very first frame after reset/restart is not a completed
                // frame, so it does not count.
                if (at_origin) begin
                    if (r_first) begin
                        r_first <= 1'b0;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
                    end
                end

                if (r_x == H_LAST) begin
                    r_x <= '0;
                    r_y <= (r_y == V_LAST) ? '0 : r_y + WIDTH'(1);
                end else begin
                    r_x <= r_x + WIDTH'(1);
                end
            end
        end
    end

    assign vt.pix_stb     = r_pix_stb;
    assign vt.line_start  = r_line_start;
    assign vt.frame_start = r_frame_start;
    assign vt.hsync       = r_hsync;
    assign vt.vsync       = r_vsync;
    assign vt.hblank      = r_hblank;
    assign vt.vblank      = r_vblank;
    assign vt.de          = r_de;
    assign vt.ord_x       = r_ord_x;
    assign vt.ord_y       = r_ord_y;
    assign vt.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_ibis_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_ibis_video_timing_gen
//
// Two instances: A is a reduced raster (29x14, CLK_DIV=3, negative syncs)
// driven cycle by cycle alongside a reference model whose per-pixel
// expectations go through a scoreboard queue; B is the tiny CLK_DIV=1 raster
// with positive syncs, checked against a hand-written table.
// -----------------------------------------------------------------------------
module tb_ibis_video_timing_gen;

    localparam int A_DIV = 3;
    localparam int A_HA = 20, A_HF = 2, A_HS = 4, A_HB = 3;
    localparam int A_VA = 8,  A_VF = 2, A_VS = 2, A_VB = 2;
    localparam int A_HT = A_HA + A_HF + A_HS + A_HB;   // 29
    localparam int A_VT = A_VA + A_VF + A_VS + A_VB;   // 14

    logic aclk = 1'b0;
    logic rstn_a;
    logic rstn_b;

    always #5 aclk = ~aclk;

    ibis_video_timing_gen_if #(.WIDTH(12), .FRAME_CNT_W(16)) vif_a ();
    ibis_video_timing_gen_if #(.WIDTH(4),  .FRAME_CNT_W(16)) vif_b ();

    ibis_video_timing_gen #(
        .WIDTH(12), .CLK_DIV(A_DIV),
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .FRAME_CNT_W(16)
    ) u_dut_a (
        .aclk    (aclk),
        .aresetn (rstn_a),
        .vt      (vif_a)
    );

    ibis_video_timing_gen #(
        .WIDTH(4), .CLK_DIV(1),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .FRAME_CNT_W(16)
    ) u_dut_b (
        .aclk    (aclk),
        .aresetn (rstn_b),
        .vt      (vif_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // {x, y, hs, vs, hb, vb, de, ls, fs, fcnt}
    function automatic logic [46:0] pk(input int x, input int y, input bit hs, input bit vs,
                                       input bit hb, input bit vb, input bit de, input bit ls,
                                       input bit fs, input int fcnt);
        return {12'(x), 12'(y), hs, vs, hb, vb, de, ls, fs, 16'(fcnt)};
    endfunction

    // ---------------- reference model for instance A ----------------
    typedef struct {
        int x; int y;
        bit hs; bit vs; bit hb; bit vb; bit de; bit ls; bit fs;
        int fcnt;
    } pix_t;

    pix_t sb_q[$];

    int m_div, m_x, m_y, m_fcnt;
    bit m_first;
    bit e_hs, e_vs, e_hb, e_vb, e_de;
    int e_ox, e_oy;

    task automatic model_reset(input bit keep_fcnt);
        m_div = 0; m_x = 0; m_y = 0; m_first = 1'b1;
        if (!keep_fcnt) m_fcnt = 0;
        e_hs = 1'b1; e_vs = 1'b1; e_hb = 1'b1; e_vb = 1'b1; e_de = 1'b0;
        e_ox = 0; e_oy = 0;
    endtask

    task automatic model_step(input bit en, input bit rs);
        pix_t p;
        bit   tk;
        if (rs) begin
            model_reset(1'b1);
        end else begin
            tk = en && (m_div == A_DIV - 1);
            if (en) m_div = (m_div + 1) % A_DIV;
            if (tk) begin
                p.x  = m_x;
                p.y  = m_y;
                p.hs = !((m_x >= A_HA + A_HF) && (m_x < A_HA + A_HF + A_HS));
                p.vs = !((m_y >= A_VA + A_VF) && (m_y < A_VA + A_VF + A_VS));
                p.hb = (m_x >= A_HA);
                p.vb = (m_y >= A_VA);
                p.de = !p.hb && !p.vb;
                p.ls = (m_x == 0);
                p.fs = (m_x == 0) && (m_y == 0);
                if (p.fs) begin
                    if (m_first) m_first = 1'b0;
                    else m_fcnt = (m_fcnt + 1) % 65536;
                end
                p.fcnt = m_fcnt;
                sb_q.push_back(p);
                e_hs = p.hs; e_vs = p.vs; e_hb = p.hb; e_vb = p.vb; e_de = p.de;
                e_ox = p.x;  e_oy = p.y;
                m_x = m_x + 1;
                if (m_x == A_HT) begin
                    m_x = 0;
                    m_y = (m_y + 1) % A_VT;
                end
            end
        end
    endtask

    task automatic check_a();
        pix_t p;
        if (vif_a.pix_stb) begin
            if (sb_q.size() == 0) begin
                chk("A unexpected pix_stb", 1, 0);
            end else begin
                p = sb_q.pop_front();
                chk("A pixel", pk(vif_a.ord_x, vif_a.ord_y, vif_a.hsync, vif_a.vsync, vif_a.hblank,
                                  vif_a.vblank, vif_a.de, vif_a.line_start, vif_a.frame_start,
                                  vif_a.frame_cnt),
                    pk(p.x, p.y, p.hs, p.vs, p.hb, p.vb, p.de, p.ls, p.fs, p.fcnt));
            end
        end else begin
            if (sb_q.size() != 0) begin
                chk("A missing pix_stb", 0, 1);
                sb_q.delete();
            end
            chk("A idle start pulses", {vif_a.line_start, vif_a.frame_start}, 0);
        end
        chk("A levels", pk(vif_a.ord_x, vif_a.ord_y, vif_a.hsync, vif_a.vsync, vif_a.hblank,
                           vif_a.vblank, vif_a.de, 0, 0, vif_a.frame_cnt),
            pk(e_ox, e_oy, e_hs, e_vs, e_hb, e_vb, e_de, 0, 0, m_fcnt));
    endtask

    // One aclk cycle of instance A: drive, predict, sample after the edge.
    task automatic step(input bit en, input bit rs);
        vif_a.enable  = en;
        vif_a.restart = rs;
        model_step(en, rs);
        @(posedge aclk);
        #1;
        check_a();
    endtask

    task automatic run_to_stb(output int n);
        bit found;
        found = 1'b0;
        n = -1;
        for (int i = 1; i <= 20 && !found; i++) begin
            step(1'b1, 1'b0);
            if (vif_a.pix_stb) begin
                n = i;
                found = 1'b1;
            end
        end
    endtask

    // Run until the pixel (x,y) is presented; y < 0 matches any line.
    task automatic run_until(input int x, input int y);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * A_HT * A_VT * A_DIV && !found; i++) begin
            step(1'b1, 1'b0);
            if (vif_a.pix_stb && vif_a.ord_x == 12'(x) && (y < 0 || vif_a.ord_y == 12'(y)))
                found = 1'b1;
        end
        if (!found) chk("A reach position", 0, 1);
    endtask

    // ---------------- table for instance B ----------------
    typedef struct {
        int k; int x; int y;
        bit hs; bit vs; bit hb; bit vb; bit de; bit ls; bit fs;
        int fcnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int   lat;
        int   fc_before;
        int   ticks, ls_cnt, hs_low, vs_low;
        bit   done;

        tbl[0]  = '{0,  0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        tbl[1]  = '{3,  3, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{4,  4, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{5,  5, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{6,  6, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{7,  7, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[6]  = '{8,  0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[7]  = '{26, 2, 3, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[8]  = '{36, 4, 4, 0, 1, 1, 1, 0, 0, 0, 0};
        tbl[9]  = '{45, 5, 5, 1, 0, 1, 1, 0, 0, 0, 0};
        tbl[10] = '{48, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        tbl[11] = '{96, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2};

        rstn_a = 1'b0; rstn_b = 1'b0;
        vif_a.enable = 1'b0; vif_a.restart = 1'b0;
        vif_b.enable = 1'b0; vif_b.restart = 1'b0;
        model_reset(1'b0);

        // ---- A: reset state and first-pixel latency ----
        repeat (3) @(posedge aclk);
        #1;
        chk("A reset outputs",
            {vif_a.pix_stb, vif_a.hsync, vif_a.vsync, vif_a.hblank, vif_a.vblank, vif_a.de,
             vif_a.line_start, vif_a.frame_start, vif_a.ord_x, vif_a.ord_y, vif_a.frame_cnt},
            {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 16'd0});
        rstn_a = 1'b1;
        run_to_stb(lat);
        chk("A first pix_stb latency", lat, 3);
        chk("A first pixel x,y,fs,de",
            {vif_a.ord_x, vif_a.ord_y, vif_a.frame_start, vif_a.de}, {12'd0, 12'd0, 1'b1, 1'b1});

        // ---- A: one full frame ----
        ticks = 1; ls_cnt = 1; hs_low = 0; vs_low = 0; done = 1'b0;
        for (int i = 0; i < 3 * A_HT * A_VT * A_DIV && !done; i++) begin
            step(1'b1, 1'b0);
            if (vif_a.pix_stb) begin
                if (vif_a.frame_start) begin
                    done = 1'b1;
                end else begin
                    ticks++;
                    if (vif_a.line_start) ls_cnt++;
                    if (!vif_a.hsync) hs_low++;
                    if (!vif_a.vsync) vs_low++;
                end
            end
        end
        chk("A second frame_start seen", done, 1);
        chk("A ticks per frame", ticks, 406);
        chk("A lines per frame", ls_cnt, 14);
        chk("A hsync active ticks", hs_low, 56);
        chk("A vsync active ticks", vs_low, 58);
        chk("A frame_cnt at 2nd frame", vif_a.frame_cnt, 1);

        // ---- A: enable gating mid-pixel ----
        run_until(10, -1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0);
            chk("A gated no strobe", vif_a.pix_stb, 0);
            chk("A gated x frozen", vif_a.ord_x, 10);
        end
        run_to_stb(lat);
        chk("A resume latency", lat, 2);
        chk("A resume x", vif_a.ord_x, 11);

        // ---- A: restart, then restart coincident with a tick ----
        run_until(15, 5);
        fc_before = vif_a.frame_cnt;
        step(1'b1, 1'b1);
        chk("A restart idle", {vif_a.pix_stb, vif_a.de, vif_a.hblank, vif_a.ord_x, vif_a.ord_y},
            {1'b0, 1'b0, 1'b1, 12'd0, 12'd0});
        run_to_stb(lat);
        chk("A restart latency", lat, 3);
        chk("A restart origin fs", {vif_a.ord_x, vif_a.ord_y, vif_a.frame_start},
            {12'd0, 12'd0, 1'b1});
        chk("A restart frame_cnt held", vif_a.frame_cnt, fc_before);
        run_until(4, -1);
        while (m_div != A_DIV - 1) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("A restart beats tick", vif_a.pix_stb, 0);
        run_to_stb(lat);
        chk("A coincident restart latency", lat, 3);
        chk("A coincident restart origin", {vif_a.ord_x, vif_a.ord_y, vif_a.frame_start},
            {12'd0, 12'd0, 1'b1});
        chk("A coincident frame_cnt held", vif_a.frame_cnt, fc_before);

        // ---- A: asynchronous reset between edges ----
        run_until(25, 10);
        #2;
        rstn_a = 1'b0;
        #1;
        chk("A async reset immediate",
            {vif_a.pix_stb, vif_a.hsync, vif_a.vsync, vif_a.hblank, vif_a.vblank, vif_a.de,
             vif_a.ord_x, vif_a.ord_y, vif_a.frame_cnt},
            {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 16'd0});
        sb_q.delete();
        model_reset(1'b0);
        @(posedge aclk);
        #1;
        rstn_a = 1'b1;
        run_to_stb(lat);
        chk("A post-reset latency", lat, 3);
        chk("A post-reset origin", {vif_a.ord_x, vif_a.ord_y, vif_a.frame_start, vif_a.frame_cnt},
            {12'd0, 12'd0, 1'b1, 16'd0});
        vif_a.enable = 1'b0;

        // ---- B: tiny raster, CLK_DIV=1 ----
        chk("B reset outputs",
            {vif_b.pix_stb, vif_b.hsync, vif_b.vsync, vif_b.hblank, vif_b.vblank, vif_b.de},
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        vif_b.enable = 1'b1;
        rstn_b = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge aclk);
            #1;
            chk("B pix_stb continuous", vif_b.pix_stb, 1);
            for (int t = 0; t < 12; t++) begin
                if (tbl[t].k == k) begin
                    chk($sformatf("B vector k=%0d", k),
                        pk(vif_b.ord_x, vif_b.ord_y, vif_b.hsync, vif_b.vsync, vif_b.hblank,
                           vif_b.vblank, vif_b.de, vif_b.line_start, vif_b.frame_start,
                           vif_b.frame_cnt),
                        pk(tbl[t].x, tbl[t].y, tbl[t].hs, tbl[t].vs, tbl[t].hb, tbl[t].vb,
                           tbl[t].de, tbl[t].ls, tbl[t].fs, tbl[t].fcnt));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
